// File: rtl/maze_job_ctrl.sv
// Maze job controller: takes a maze bitstream from the host, replays it into the
// solver, then watches the solver's answer (no-path flag, timeout, or a path
// stream that must be a unit-step walk from START to GOAL) and reports a result.
module maze_job_ctrl #(
  parameter int MAZE_BITS = 225,
  parameter int TIMEOUT   = 1023,
  parameter int START_X   = 1,
  parameter int START_Y   = 1,
  parameter int GOAL_X    = 13,
  parameter int GOAL_Y    = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_start,
  input  logic       host_abort,
  input  logic       host_bit,
  input  logic       host_bit_valid,
  output logic       host_ready,
  output logic       busy,
  output logic       res_valid,
  output logic [1:0] res_status,
  output logic [7:0] res_len,
  output logic       ms_in_valid,
  output logic       ms_maze,
  input  logic       ms_out_valid,
  input  logic       ms_not_valid,
  input  logic [3:0] ms_x,
  input  logic [3:0] ms_y
);

  localparam int CW = $clog2(MAZE_BITS + 1);
  localparam int WW = $clog2(TIMEOUT + 1) + 1;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_NOPATH  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_PATHERR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FEED, S_WAIT, S_STREAM, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MAZE_BITS-1:0]   buf_q, buf_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic [7:0]             len_q, len_d;
  logic [1:0]             status_q, status_d;
  logic                   err_q, err_d;
  logic [3:0]             px_q, px_d, py_q, py_d;

  logic                   abort_act;
  logic                   cnt_last;
  logic                   wd_expired;
  logic [3:0]             dx, dy;
  logic                   step_ok;
  logic                   at_start;
  logic                   at_goal;
  logic [7:0]             len_inc;

  assign abort_act  = host_abort && (state_q != S_IDLE);
  assign cnt_last   = (cnt_q == CW'(MAZE_BITS - 1));
  assign wd_expired = (wd_q == WW'(TIMEOUT));
  assign dx         = (ms_x >= px_q) ? (ms_x - px_q) : (px_q - ms_x);
  assign dy         = (ms_y >= py_q) ? (ms_y - py_q) : (py_q - ms_y);
  assign step_ok    = ((dx == 4'd1) && (dy == 4'd0)) || ((dx == 4'd0) && (dy == 4'd1));
  assign at_start   = (ms_x == 4'(START_X)) && (ms_y == 4'(START_Y));
  assign at_goal    = (px_q == 4'(GOAL_X)) && (py_q == 4'(GOAL_Y));
  assign len_inc    = (len_q == 8'hFF) ? len_q : (len_q + 8'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    if (abort_act) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (host_start) state_d = S_LOAD;
        S_LOAD:   if (host_bit_valid && cnt_last) state_d = S_FEED;
        S_FEED:   if (cnt_last) state_d = S_WAIT;
        S_WAIT: begin
          if (ms_not_valid)      state_d = S_DONE;
          else if (ms_out_valid) state_d = S_STREAM;
          else if (wd_expired)   state_d = S_DONE;
        end
        S_STREAM: if (ms_not_valid || !ms_out_valid) state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output decode; result strobe is suppressed if an abort lands on DONE
  always_comb begin
    host_ready  = (state_q == S_LOAD);
    busy        = (state_q != S_IDLE);
    res_valid   = (state_q == S_DONE) && !host_abort;
    ms_in_valid = (state_q == S_FEED);
    ms_maze     = (state_q == S_FEED) ? buf_q[MAZE_BITS-1] : 1'b0;
    res_status  = status_q;
    res_len     = len_q;
  end

  // Datapath: bit buffer, counters, path tracking and result capture
  always_comb begin
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    wd_d     = wd_q;
    len_d    = len_q;
    status_d = status_q;
    err_d    = err_q;
    px_d     = px_q;
    py_d     = py_q;
    if (!abort_act) begin
      case (state_q)
        S_IDLE: begin
          if (host_start) begin
            cnt_d    = '0;
            wd_d     = '0;
            len_d    = '0;
            status_d = ST_OK;
            err_d    = 1'b0;
          end
        end
        S_LOAD: begin
          // Bits enter at the LSB so the first accepted bit ends up at the MSB
          if (host_bit_valid) begin
            buf_d = {buf_q[MAZE_BITS-2:0], host_bit};
            cnt_d = cnt_last ? '0 : (cnt_q + CW'(1));
          end
        end
        S_FEED: begin
          buf_d = {buf_q[MAZE_BITS-2:0], 1'b0};
          cnt_d = cnt_last ? '0 : (cnt_q + CW'(1));
        end
        S_WAIT: begin
          if (ms_not_valid) begin
            status_d = ST_NOPATH;
          end else if (ms_out_valid) begin
            len_d = 8'd1;
            err_d = !at_start;
            px_d  = ms_x;
            py_d  = ms_y;
          end else if (wd_expired) begin
            status_d = ST_TIMEOUT;
          end else begin
            wd_d = wd_q + WW'(1);
          end
        end
        S_STREAM: begin
          if (ms_not_valid) begin
            status_d = ST_PATHERR;
          end else if (ms_out_valid) begin
            len_d = len_inc;
            err_d = err_q || !step_ok;
            px_d  = ms_x;
            py_d  = ms_y;
          end else begin
            status_d = (err_q || !at_goal) ? ST_PATHERR : ST_OK;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      buf_q    <= '0;
      wd_q     <= '0;
      len_q    <= '0;
      status_q <= ST_OK;
      err_q    <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      wd_q     <= wd_d;
      len_q    <= len_d;
      status_q <= status_d;
      err_q    <= err_d;
      px_q     <= px_d;
      py_q     <= py_d;
    end
  end

endmodule

// File: tb/tb_maze_job_ctrl.sv
// Bench for maze_job_ctrl: random maze bits with random gaps, a queue-based
// reference for the solver feed, and a path checker computed from the walk rules.
module tb_maze_job_ctrl;

  localparam int MB = 225;
  localparam int TO = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_start = 1'b0, host_abort = 1'b0, host_bit = 1'b0, host_bit_valid = 1'b0;
  logic       host_ready, busy, res_valid, ms_in_valid, ms_maze;
  logic [1:0] res_status;
  logic [7:0] res_len;
  logic       ms_out_valid = 1'b0, ms_not_valid = 1'b0;
  logic [3:0] ms_x = 4'd0, ms_y = 4'd0;

  always #5 clk = ~clk;

  maze_job_ctrl dut (
    .clk(clk), .rst(rst),
    .host_start(host_start), .host_abort(host_abort),
    .host_bit(host_bit), .host_bit_valid(host_bit_valid),
    .host_ready(host_ready), .busy(busy),
    .res_valid(res_valid), .res_status(res_status), .res_len(res_len),
    .ms_in_valid(ms_in_valid), .ms_maze(ms_maze),
    .ms_out_valid(ms_out_valid), .ms_not_valid(ms_not_valid),
    .ms_x(ms_x), .ms_y(ms_y)
  );

  int errors = 0;
  int checks = 0;

  // Monitor: records everything the solver is fed and every result strobe
  bit         fed[$];
  int         cyc = 0, feed_runs = 0, last_feed_cyc = 0, rv_count = 0, rv_cyc = 0;
  logic       prev_iv = 1'b0;
  logic [1:0] rv_status = 2'd0;
  logic [7:0] rv_len = 8'd0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ms_in_valid === 1'b1) begin
      fed.push_back(ms_maze);
      last_feed_cyc <= cyc + 1;
      if (!prev_iv) feed_runs <= feed_runs + 1;
    end
    prev_iv <= (ms_in_valid === 1'b1);
    if (res_valid === 1'b1) begin
      rv_count  <= rv_count + 1;
      rv_cyc    <= cyc + 1;
      rv_status <= res_status;
      rv_len    <= res_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference state
  bit exp_bits[$];
  int px[$], py[$];
  int g_base, g_runs, g_rc;

  task automatic start_job();
    tick();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  // Host sends n random bits with random idle gaps; solver lines toggle as noise
  task automatic load_bits(input int n);
    exp_bits.delete();
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        host_bit_valid = 1'b0;
        ms_out_valid   = 1'($urandom_range(0, 1));
        ms_not_valid   = 1'($urandom_range(0, 1));
        tick();
      end
      host_bit       = 1'($urandom_range(0, 1));
      host_bit_valid = 1'b1;
      ms_out_valid   = 1'($urandom_range(0, 1));
      ms_not_valid   = 1'($urandom_range(0, 1));
      exp_bits.push_back(host_bit);
      tick();
    end
    host_bit_valid = 1'b0;
    ms_out_valid   = 1'b0;
    ms_not_valid   = 1'b0;
  endtask

  task automatic wait_feed();
    int k = 0;
    while (k < 1000 && !(fed.size() >= g_base + MB && ms_in_valid === 1'b0)) begin
      tick();
      k++;
    end
    chk("feed_done_in_time", 32'(k < 1000), 1);
  endtask

  task automatic check_feed();
    int mism = 0;
    chk("feed_count", fed.size() - g_base, MB);
    for (int i = 0; i < MB && g_base + i < fed.size(); i++)
      if (fed[g_base + i] !== exp_bits[i]) mism++;
    chk("feed_order", mism, 0);
    chk("feed_contiguous", feed_runs - g_runs, 1);
  endtask

  task automatic do_feed();
    g_base = fed.size();
    g_runs = feed_runs;
    g_rc   = rv_count;
    start_job();
    chk("busy_in_load", busy, 1);
    chk("ready_in_load", host_ready, 1);
    load_bits(MB);
    wait_feed();
    check_feed();
  endtask

  task automatic wait_result(input int bound);
    int k = 0;
    while (k < bound && rv_count == g_rc) begin
      tick();
      k++;
    end
    chk("res_valid_once", rv_count - g_rc, 1);
    tick();
    chk("idle_after_done", busy, 0);
    chk("no_extra_res_valid", rv_count - g_rc, 1);
  endtask

  // Path construction helpers
  task automatic walk_to(input int tx, input int ty);
    while (px[px.size()-1] != tx) begin
      px.push_back(px[px.size()-1] + ((tx > px[px.size()-1]) ? 1 : -1));
      py.push_back(py[py.size()-1]);
    end
    while (py[py.size()-1] != ty) begin
      px.push_back(px[px.size()-1]);
      py.push_back(py[py.size()-1] + ((ty > py[py.size()-1]) ? 1 : -1));
    end
  endtask

  task automatic path_reset(input int x0, input int y0);
    px.delete();
    py.delete();
    px.push_back(x0);
    py.push_back(y0);
  endtask

  // Reference verdict from the walk rules
  task automatic model(output int st, output int ln);
    int n = px.size();
    bit bad = (px[0] != 1) || (py[0] != 1);
    for (int i = 1; i < n; i++) begin
      int ax = (px[i] > px[i-1]) ? px[i] - px[i-1] : px[i-1] - px[i];
      int ay = (py[i] > py[i-1]) ? py[i] - py[i-1] : py[i-1] - py[i];
      if (ax + ay != 1) bad = 1'b1;
    end
    if (px[n-1] != 13 || py[n-1] != 13) bad = 1'b1;
    st = bad ? 3 : 0;
    ln = (n > 255) ? 255 : n;
  endtask

  task automatic send_path_and_check(input string tag);
    int st, ln;
    model(st, ln);
    for (int i = 0; i < px.size(); i++) begin
      ms_out_valid = 1'b1;
      ms_x = 4'(px[i]);
      ms_y = 4'(py[i]);
      tick();
    end
    ms_out_valid = 1'b0;
    wait_result(50);
    chk({tag, "_status"}, rv_status, st);
    chk({tag, "_len"}, rv_len, ln);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", host_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ms_in_valid", ms_in_valid, 0);
    chk("rst_ms_maze", ms_maze, 0);
    chk("rst_status", res_status, 0);
    chk("rst_len", res_len, 0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal job
    do_feed();
    path_reset(1, 1); walk_to(1, 13); walk_to(13, 13);
    chk("nominal_path_points", px.size(), 25);
    send_path_and_check("nominal");

    // Dead maze: no-path flag 10 cycles after feed ends
    do_feed();
    repeat (9) tick();
    ms_not_valid = 1'b1;
    tick();
    ms_not_valid = 1'b0;
    wait_result(20);
    chk("dead_status", rv_status, 1);
    chk("dead_len", rv_len, 0);

    // Timeout: silent solver
    do_feed();
    wait_result(TO + 50);
    chk("timeout_status", rv_status, 2);
    chk("timeout_delay", rv_cyc - (last_feed_cyc + 1), TO + 1);

    // Diagonal step in the path
    do_feed();
    path_reset(1, 1); walk_to(2, 1); walk_to(2, 2);
    px.push_back(3); py.push_back(3);
    walk_to(13, 3); walk_to(13, 13);
    send_path_and_check("diag");

    // Path ends one short of the goal
    do_feed();
    path_reset(1, 1); walk_to(1, 13); walk_to(12, 13);
    send_path_and_check("short");

    // Reset in the middle of the feed, with a nonzero status held
    g_base = fed.size();
    start_job();
    load_bits(MB);
    repeat (20) tick();
    chk("midfeed_active", ms_in_valid, 1);
    rst = 1'b1;
    #1;
    chk("midfeed_rst_in_valid", ms_in_valid, 0);
    chk("midfeed_rst_busy", busy, 0);
    chk("midfeed_rst_status", res_status, 0);
    // First start after release goes straight in
    @(negedge clk);
    rst = 1'b0;
    host_start = 1'b1;
    @(posedge clk);
    #1;
    host_start = 1'b0;
    chk("post_rst_start_ready", host_ready, 1);
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    chk("post_rst_abort_idle", busy, 0);

    // Long legal path: length saturates at 255
    do_feed();
    path_reset(1, 1);
    for (int i = 0; i < 140; i++) begin
      px.push_back(1); py.push_back(2);
      px.push_back(1); py.push_back(1);
    end
    walk_to(1, 13); walk_to(13, 13);
    send_path_and_check("saturate");

    // Abort at bit 100, then a fresh job sees only its own bits
    g_rc = rv_count;
    start_job();
    load_bits(100);
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", host_ready, 0);
    repeat (5) tick();
    chk("abort_no_res_valid", rv_count - g_rc, 0);
    do_feed();
    path_reset(1, 1); walk_to(13, 1); walk_to(13, 13);
    send_path_and_check("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maze_job_ctrl.md
MAZE_JOB_CTRL -- requirements
Module: maze_job_ctrl

Interface
REQ-001 Parameter MAZE_BITS, default 225, SHALL set the number of maze cells per job.
REQ-002 Parameter TIMEOUT, default 1023, SHALL set the solver watchdog limit in cycles.
REQ-003 Parameters START_X/START_Y, default 1/1, and GOAL_X/GOAL_Y, default 13/13, SHALL set the required path endpoints.
REQ-004 Ports SHALL be as listed; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  async reset, active-high.
- host_start  in  1  one-cycle job request.
- host_abort  in  1  cancel current job.
- host_bit  in  1  maze cell, 1 = wall.
- host_bit_valid  in  1  host_bit qualifier.
- host_ready  out  1  controller accepting maze bits.
- busy  out  1  job in progress.
- res_valid  out  1  one-cycle result strobe.
- res_status  out  2  0 OK, 1 maze not valid, 2 timeout, 3 path error.
- res_len  out  8  path points received, saturating.
- ms_in_valid  out  1  solver load strobe.
- ms_maze  out  1  solver maze bit.
- ms_out_valid  in  1  solver path point valid.
- ms_not_valid  in  1  solver no-path flag.
- ms_x, ms_y  in  4 each  solver path coordinate.

Function
REQ-005 States SHALL be IDLE, LOAD, FEED, WAIT, STREAM, DONE.
REQ-006 IDLE: host_start -> LOAD; bit count, res_len, watchdog cleared; host_start in any other state ignored.
REQ-007 LOAD: host_ready=1; each host_bit_valid&host_ready cycle shifts host_bit into a MAZE_BITS buffer; gaps allowed; accepting bit MAZE_BITS -> FEED next cycle.
REQ-008 FEED: ms_in_valid=1 for exactly MAZE_BITS consecutive cycles, ms_maze = buffered bits in host arrival order (first accepted bit first); then WAIT.
REQ-009 ms_in_valid SHALL be 0 and ms_maze 0 outside FEED.
REQ-010 WAIT: watchdog increments per cycle; ms_not_valid -> DONE status 1; ms_out_valid -> STREAM with that point processed as the first point; watchdog == TIMEOUT with neither -> DONE status 2; ms_not_valid has priority over ms_out_valid.
REQ-011 STREAM: each ms_out_valid cycle increments res_len, saturating at 255.
REQ-012 Path check: first point SHALL equal (START_X,START_Y); each next point SHALL differ from the previous by exactly 1 in exactly one coordinate; any violation latches a sticky error.
REQ-013 STREAM ends on first cycle with ms_out_valid=0 -> DONE; status 3 if sticky error or last point != (GOAL_X,GOAL_Y), else 0.
REQ-014 ms_not_valid during STREAM -> DONE status 3 immediately.
REQ-015 DONE: res_valid=1 for one cycle, then IDLE; res_status/res_len hold until next accepted host_start.
REQ-016 busy=1 in all states except IDLE.
REQ-017 host_abort in any non-IDLE state -> IDLE next cycle, no res_valid, ms_in_valid dropped; abort has priority over every other transition.
REQ-018 ms_out_valid/ms_not_valid outside WAIT/STREAM SHALL be ignored.

Reset
REQ-019 rst SHALL force IDLE and all outputs to 0 asynchronously, mid-job included, with buffer contents don't-care.
REQ-020 First host_start after rst deassertion SHALL be accepted on the first clk edge.

Verification
REQ-021 Nominal: start, 225 bits with random gaps, solver path (1,1)->(1,2)->...->(13,13) of 25 points -> 225-cycle contiguous ms_in_valid in order, res_valid, status 0, len 25.
REQ-022 Dead maze: ms_not_valid 10 cycles after FEED -> status 1, len 0.
REQ-023 Timeout: no solver response -> res_valid exactly TIMEOUT+1 cycles after WAIT entry, status 2.
REQ-024 Bad path: diagonal step (2,2)->(3,3), or last point (12,13) -> status 3, len counted.
REQ-025 Abort at bit 100 of LOAD, then new job -> no res_valid for first job, second job feeds only its own 225 bits.
REQ-026 rst mid-FEED -> ms_in_valid 0 immediately, busy 0, res_status 0.
